// File: rtl/pwm_pkg.sv
// pwm_pkg: shared bus widths, master FSM encoding and PWM register map.
package pwm_pkg;
    localparam int WB_ADR_W = 16;
    localparam int WB_DAT_W = 16;
    typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;
    localparam logic [WB_ADR_W-1:0] ADR_CTRL    = 16'd0;
    localparam logic [WB_ADR_W-1:0] ADR_DIVISOR = 16'd2;
    localparam logic [WB_ADR_W-1:0] ADR_PERIOD  = 16'd4;
    localparam logic [WB_ADR_W-1:0] ADR_DUTY    = 16'd6;
    localparam int CTRL_EXT_CLK  = 0;
    localparam int CTRL_PWM_MODE = 1;
    localparam int CTRL_CNT_EN   = 2;
    localparam int CTRL_CONT     = 3;
    localparam int CTRL_OUT_EN   = 4;
    localparam int CTRL_IRQ_CLR  = 5;
    localparam int CTRL_DUTY_SEL = 6;
    localparam int CTRL_SOFT_RST = 7;
endpackage

// File: rtl/wb_cfg_master_if.sv
// wb_cfg_master_if: command push port, Wishbone write bus and status of the config master.
interface wb_cfg_master_if;
    import pwm_pkg::*;
    logic                i_cmd_valid;
    logic                o_cmd_ready;
    logic [WB_ADR_W-1:0] i_cmd_adr;
    logic [WB_DAT_W-1:0] i_cmd_data;
    logic                o_wb_cyc;
    logic                o_wb_stb;
    logic                o_wb_we;
    logic [WB_ADR_W-1:0] o_wb_adr;
    logic [WB_DAT_W-1:0] o_wb_data;
    logic                i_wb_ack;
    logic                o_busy;
    logic                o_timeout;
    logic                i_timeout_clr;
    modport master (
        input  i_cmd_valid, i_cmd_adr, i_cmd_data, i_wb_ack, i_timeout_clr,
        output o_cmd_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data, o_busy, o_timeout
    );
    modport slave (
        output i_cmd_valid, i_cmd_adr, i_cmd_data, i_wb_ack, i_timeout_clr,
        input  o_cmd_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data, o_busy, o_timeout
    );
endinterface

// File: rtl/wb_cmd_fifo.sv
// wb_cmd_fifo: small synchronous FIFO holding {adr, data} write commands.
module wb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            din,
    output logic [W-1:0]            dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/wb_cfg_master.sv
// wb_cfg_master: drains queued (adr, data) commands as single Wishbone classic writes
// with an ack timeout that drops the command and raises a sticky flag.
module wb_cfg_master import pwm_pkg::*; #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    wb_cfg_master_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [WB_ADR_W-1:0] adr_q;
    logic [WB_DAT_W-1:0] dat_q;
    logic                to_q, push, pop, load, set_to, full, empty;
    logic [AW:0]         count;
    logic [WB_ADR_W+WB_DAT_W-1:0] head;
    assign push = bus.i_cmd_valid & ~full;
    wb_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(WB_ADR_W + WB_DAT_W)) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (push),
        .pop   (pop),
        .din   ({bus.i_cmd_adr, bus.i_cmd_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    // An ack on the last allowed cycle wins over the timeout.
    always_comb begin
        load    = state_q == IDLE && !empty;
        pop     = state_q == BUS && (bus.i_wb_ack || cnt_q == LAST);
        set_to  = pop && !bus.i_wb_ack;
        state_d = load ? BUS : pop ? IDLE : state_q;
    end
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= state_q == IDLE ? '0 : cnt_q == LAST ? cnt_q : cnt_q + CW'(1);
            adr_q <= load ? head[WB_ADR_W+WB_DAT_W-1:WB_DAT_W] : adr_q;
            dat_q <= load ? head[WB_DAT_W-1:0] : dat_q;
            to_q  <= set_to | (to_q & ~bus.i_timeout_clr);
        end
    end
    assign bus.o_wb_cyc    = state_q == BUS;
    assign bus.o_wb_stb    = state_q == BUS;
    assign bus.o_wb_we     = state_q == BUS;
    assign bus.o_wb_adr    = adr_q;
    assign bus.o_wb_data   = dat_q;
    assign bus.o_timeout   = to_q;
    assign bus.o_cmd_ready = ~full;
    assign bus.o_busy      = (count != '0) | (state_q == BUS);
endmodule

// File: tb/tb_wb_cfg_master.sv
// tb_wb_cfg_master: directed table plus randomized traffic against a transaction-level
// scoreboard of queued commands, responder wait states and the sticky timeout flag.
module tb_wb_cfg_master;
    localparam int DEPTH = 4;
    localparam int TO    = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    wb_cfg_master_if bus();
    wb_cfg_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    int n_cmp = 0, n_err = 0, cyc_n = 0, pushed = 0, completed = 0;
    int acc_cyc = 0, last_start = 0, last_dur = 0, dur = 0, cur_d = 0;
    logic [31:0] exp_q[$];
    int delay_q[$];
    logic in_tx = 0, exp_to = 0, clr_prev = 0, set_now = 0;
    logic rand_on = 0, spur = 0, clr_last = 0, clr_pulse = 0;
    logic [15:0] st_adr, st_dat;
    typedef struct {
        logic [15:0] adr;
        logic [15:0] dat;
        int          delay;
        int          dur;
        logic        to;
    } vec_t;
    vec_t tbl[6];
    always @(posedge clk) cyc_n <= cyc_n + 1;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic push(input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_adr   = a;
        bus.i_cmd_data  = d;
        while (!bus.o_cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_wait: ready stuck at 0, required 1");
            bus.i_cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.i_cmd_valid = 1'b0;
        exp_q.push_back({a, d});
        pushed++;
        acc_cyc = cyc_n;
    endtask
    task automatic wait_done(input int target);
        int n = 0;
        while (completed < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("tx_done", completed >= target, 1);
    endtask
    // Responder and scoreboard: every bus write must match the oldest accepted command,
    // last min(delay+1, TO) cycles, and a write that outlives TO cycles sets the flag.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            in_tx = 0;
            exp_to = 0;
            clr_prev = 0;
            bus.i_wb_ack = 1'b0;
            bus.i_timeout_clr = 1'b0;
        end else begin
            set_now = 0;
            if (bus.o_wb_cyc && !in_tx) begin
                in_tx = 1;
                dur = 0;
                cur_d = (delay_q.size() > 0) ? delay_q.pop_front() : int'($urandom_range(0, 17));
                st_adr = bus.o_wb_adr;
                st_dat = bus.o_wb_data;
                last_start = cyc_n;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_cycle: got write adr %0h, required no bus activity", st_adr);
                end else check("bus_order", {st_adr, st_dat}, exp_q[0]);
            end
            if (bus.o_wb_cyc) begin
                dur++;
                check("bus_hold", {bus.o_wb_stb, bus.o_wb_we, bus.o_wb_adr, bus.o_wb_data}, {2'b11, st_adr, st_dat});
            end else begin
                check("bus_idle", {bus.o_wb_stb, bus.o_wb_we}, 0);
                if (in_tx) begin
                    in_tx = 0;
                    last_dur = dur;
                    set_now = cur_d >= TO;
                    check("bus_len", dur, (cur_d + 1 < TO) ? cur_d + 1 : TO);
                    if (exp_q.size() > 0) exp_q.delete(0);
                    completed++;
                end
            end
            exp_to = set_now ? 1'b1 : clr_prev ? 1'b0 : exp_to;
            check("cmd_ready", bus.o_cmd_ready, (pushed - completed) < DEPTH);
            check("busy", bus.o_busy, pushed != completed);
            check("timeout_flag", bus.o_timeout, exp_to);
            bus.i_wb_ack = bus.o_wb_cyc ? (dur == cur_d + 1) : (spur || (rand_on && $urandom_range(0, 3) == 0));
            bus.i_timeout_clr = clr_pulse || (clr_last && bus.o_wb_cyc && dur == TO) ||
                                (rand_on && $urandom_range(0, 7) == 0);
            clr_pulse = 0;
            clr_prev = bus.i_timeout_clr;
        end
    end
    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end
    initial begin
        int c0;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_adr = '0;
        bus.i_cmd_data = '0;
        bus.i_wb_ack = 1'b0;
        bus.i_timeout_clr = 1'b0;
        tbl[0] = '{16'd4, 16'h00FF, 0, 1, 1'b0};
        tbl[1] = '{16'd2, 16'h1234, 3, 4, 1'b0};
        tbl[2] = '{16'd6, 16'hBEEF, 99, 16, 1'b1};
        tbl[3] = '{16'd0, 16'h0055, 15, 16, 1'b0};
        tbl[4] = '{16'd6, 16'hA5A5, 14, 15, 1'b0};
        tbl[5] = '{16'd2, 16'hFFFF, 16, 16, 1'b1};
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we, bus.o_wb_adr, bus.o_wb_data, bus.o_timeout}, 0);
        check("rst_ready", bus.o_cmd_ready, 1);
        check("rst_busy", bus.o_busy, 0);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            c0 = completed;
            delay_q.push_back(tbl[i].delay);
            push(tbl[i].adr, tbl[i].dat);
            wait_done(c0 + 1);
            check("vec_len", last_dur, tbl[i].dur);
            check("vec_timeout", bus.o_timeout, tbl[i].to);
            check("vec_latency", last_start - acc_cyc, 1);
            clr_pulse = 1;
            repeat (3) @(posedge clk);
            #1;
        end
        // timeout, then the queued command behind it still goes out
        c0 = completed;
        delay_q.push_back(99);
        delay_q.push_back(2);
        push(16'd4, 16'h0001);
        push(16'd6, 16'h0002);
        wait_done(c0 + 2);
        check("after_timeout_len", last_dur, 3);
        check("after_timeout_flag", bus.o_timeout, 1);
        clr_pulse = 1;
        repeat (2) @(posedge clk);
        #1;
        check("clr_pulse", bus.o_timeout, 0);
        // clear asserted on the very edge the timeout fires
        clr_last = 1;
        c0 = completed;
        delay_q.push_back(99);
        push(16'd0, 16'h0084);
        wait_done(c0 + 1);
        check("set_wins", bus.o_timeout, 1);
        clr_last = 0;
        clr_pulse = 1;
        repeat (2) @(posedge clk);
        #1;
        check("clr_after_set_wins", bus.o_timeout, 0);
        // backpressure: five back-to-back pushes behind a slow first ack
        c0 = completed;
        delay_q = '{10, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) push(16'(2 * i), 16'(16'h1100 + i));
        check("bp_ready_low", bus.o_cmd_ready, 0);
        push(16'd6, 16'h1104);
        check("bp_after_ack", completed >= c0 + 1, 1);
        wait_done(c0 + 5);
        // acks while idle must not pop anything
        spur = 1;
        repeat (4) @(posedge clk);
        c0 = completed;
        delay_q.push_back(5);
        push(16'd2, 16'h0F0F);
        wait_done(c0 + 1);
        check("spur_len", last_dur, 6);
        spur = 0;
        // reset in the middle of a write with three more queued
        delay_q = '{99, 0, 0, 0};
        for (int i = 0; i < 4; i++) push(16'(2 * i), 16'(16'h2200 + i));
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_cyc", bus.o_wb_cyc, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_cyc", {bus.o_wb_cyc, bus.o_wb_stb}, 0);
        check("rst_async_busy", bus.o_busy, 0);
        check("rst_async_ready", bus.o_cmd_ready, 1);
        exp_q.delete();
        delay_q.delete();
        pushed = 0;
        completed = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        delay_q.push_back(0);
        push(16'd4, 16'h3333);
        wait_done(1);
        check("post_rst_len", last_dur, 1);
        // randomized traffic, acks, spurious acks and flag clears
        rand_on = 1;
        repeat (400) begin
            if ($urandom_range(0, 2) == 0) push(16'($urandom), 16'($urandom));
            else @(posedge clk);
        end
        rand_on = 0;
        c0 = 0;
        while (pushed != completed && c0 < 1000) begin
            @(posedge clk);
            c0++;
        end
        #1;
        check("drain", pushed == completed, 1);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_cfg_master.md
# wb_cfg_master

Wishbone classic initiator that programs the PWM/timer register file over the same single-write bus the PWM top consumes. Local logic such as a sequencer or test controller pushes (address, data) write commands into a small FIFO. The block issues each command as one Wishbone write, waits for `i_wb_ack`, and reports an error on an ack timeout. It sits on the bus-master side of the PWM top's Wishbone port.

## Interface
- `FIFO_DEPTH`, default 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT`, default 16: maximum cycles in BUS without ack before abort; ≥2.
- `i_clk`  in  1: single clock.
- `i_rst`  in  1: reset, asynchronous, active-low.
- `i_cmd_valid`  in  1: command push request.
- `o_cmd_ready`  out  1: FIFO not full.
- `i_cmd_adr`  in  16: target register address.
- `i_cmd_data`  in  16: write data.
- `o_wb_cyc`  out  1: Wishbone cycle.
- `o_wb_stb`  out  1: Wishbone strobe.
- `o_wb_we`  out  1: write enable; always 1 when `o_wb_stb` is 1.
- `o_wb_adr`  out  16: bus address.
- `o_wb_data`  out  16: bus write data.
- `i_wb_ack`  in  1: responder acknowledge.
- `o_busy`  out  1: FIFO non-empty or transaction in flight.
- `o_timeout`  out  1: sticky ack-timeout flag.
- `i_timeout_clr`  in  1: clears `o_timeout`.

## Operation
- Push: a command is accepted on a rising edge with `i_cmd_valid && o_cmd_ready`. `o_cmd_ready` = count < `FIFO_DEPTH`, computed combinationally from the registered count.
- Simultaneous push and pop when full: push is refused because ready is low. Simultaneous push and pop otherwise: count is unchanged and both take effect.
- FSM, two states:
  - IDLE: cyc/stb/we = 0. If the FIFO is non-empty, register the head adr/data into `o_wb_adr`/`o_wb_data` and go to BUS. The timeout counter is cleared.
  - BUS: cyc = stb = we = 1; adr/data are held stable.
    - `i_wb_ack` = 1 on an edge: pop the head and go to IDLE.
    - Otherwise the counter increments. If the counter reaches `TIMEOUT - 1` with no ack: pop (drop) the command, set `o_timeout`, go to IDLE.
- Ack handling:
  - Ack in IDLE is ignored.
  - Ack on the same edge as the timeout condition counts as success; `o_timeout` is not set.
- `o_timeout` is sticky. `i_timeout_clr` clears it.
  - Set and clear on the same edge: set wins.
- `o_busy` = (count ≠ 0) | (state == BUS).
- Counter width is clog2(`TIMEOUT`). The counter saturates and never wraps.
- FIFO pointers are clog2(`FIFO_DEPTH`) bits and wrap naturally. Count is one bit wider.

## Timing
- Reset values: state IDLE, `o_wb_cyc`/`o_wb_stb`/`o_wb_we` = 0, `o_wb_adr`/`o_wb_data` = 0, `o_timeout` = 0, FIFO empty, `o_cmd_ready` = 1, `o_busy` = 0.
- Reset asserted mid-transaction: cyc/stb drop asynchronously and the FIFO is flushed. No partial command is retried.
- Latency:
  - Command accepted at edge N into an empty FIFO with the FSM idle: cyc/stb high after edge N+1.
  - Ack sampled at edge M: cyc/stb low after edge M.
  - Next queued command: cyc/stb high after edge M+1.
- Every transaction has a minimum one-cycle gap.
- Throughput: one write per 2 cycles, given a zero-wait responder that acks in the first BUS cycle.
- Timeout: with no ack, cyc stays high for exactly `TIMEOUT` cycles, then drops. `o_timeout` is high after that same edge.
- All outputs are registered except `o_cmd_ready` and `o_busy`, which are decoded from registers only.

## Structure
- The shared package `pwm_pkg` holds:
  - `WB_ADR_W` = 16 and `WB_DAT_W` = 16.
  - State encoding: IDLE = 0, BUS = 1.
  - Register address constants: CTRL = 0, DIVISOR = 2, PERIOD = 4, DUTY = 6.
  - CTRL bit positions:
    - EXT_CLK = 0
    - PWM_MODE = 1
    - CNT_EN = 2
    - CONT = 3
    - OUT_EN = 4
    - IRQ_CLR = 5
    - DUTY_SEL = 6
    - SOFT_RST = 7
- One sub-module, `wb_cmd_fifo`: synchronous 32-bit-wide FIFO with push/pop/full/empty/count and asynchronous active-low reset. The FSM and bus registers live in `wb_cfg_master`.

## Test plan
- Single write: push (adr 4, data 0x00FF) to an idle block; responder acks on the first stb cycle. Expect:
  - cyc/stb/we high for 1 cycle, starting 1 cycle after accept, with adr = 4 and data = 0x00FF.
  - `o_busy` low afterward.
- Burst and backpressure: push 5 commands back-to-back with ack held off. Expect:
  - `o_cmd_ready` low while count = 4.
  - The 5th command is accepted only after the first ack.
  - Bus order is preserved, with a 1-cycle gap between writes.
- Wait states: responder delays ack by 3 cycles. Expect cyc high for 4 cycles, adr/data stable throughout, and `o_timeout` = 0.
- Timeout: responder never acks, `TIMEOUT` = 16. Expect:
  - cyc high for exactly 16 cycles, then `o_timeout` = 1.
  - The next queued command is issued.
  - `i_timeout_clr` pulse returns `o_timeout` to 0.
- Edge cases:
  - Ack on the final timeout cycle: success, no flag.
  - Spurious ack in IDLE: no pop, count unchanged.
  - Set and clear of `o_timeout` on the same edge: the flag stays 1.
- Reset mid-BUS with 3 commands queued. Expect:
  - cyc low immediately (asynchronously).
  - `o_busy` = 0 and `o_cmd_ready` = 1.
  - No bus activity after release until a new push.
